// File: rtl/arrayadd_ctrl.sv
// arrayadd_ctrl: streams RESULT[i] = A[i] + B[i] over a wrapping index window
// [base, base+len). Reads are issued one per cycle; each sum is written one
// cycle after its read. Optional running-sum output 'total' is built when
// ARRAYADD_CTRL_SUM_EN is defined.
module arrayadd_ctrl #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] a_data,
    input  logic [DW-1:0] b_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          carry
`ifdef ARRAYADD_CTRL_SUM_EN
    ,
    output logic [DW-1:0] total
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_base;
    logic [AW:0]   r_len;
    logic [AW:0]   r_cnt;
    logic          r_wr_pend;
    logic [AW-1:0] r_wr_addr;
    logic          r_carry;

    logic          w_accept;
    logic [AW:0]   w_cnt_nxt;
    logic [DW:0]   w_sum;
    logic          w_wr_fire;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_sum     = {1'b0, a_data} + {1'b0, b_data};
    // abort squashes the write that would land in the aborting cycle
    assign w_wr_fire = r_wr_pend && !abort;

    assign rd_en   = (r_state == S_READ);
    assign rd_addr = r_base + r_cnt[AW-1:0];
    assign wr_en   = w_wr_fire;
    assign wr_addr = r_wr_addr;
    assign wr_data = w_wr_fire ? w_sum[DW-1:0] : '0;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign carry   = r_carry;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; start beats abort in IDLE, abort exits READ/DRAIN
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_READ;
            S_READ:  if (abort) w_next = S_IDLE;
                     else if (w_cnt_nxt == r_len) w_next = S_DRAIN;
            S_DRAIN: w_next = abort ? S_IDLE : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job capture, read counter, one-cycle write pipeline and sticky carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wr_pend <= 1'b0;
            r_wr_addr <= '0;
            r_carry   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base <= base;
                r_len  <= len;
                r_cnt  <= '0;
            end else if (rd_en) begin
                r_cnt  <= w_cnt_nxt;
            end
            r_wr_pend <= rd_en && !abort;
            if (rd_en) r_wr_addr <= rd_addr;
            if (w_accept)                    r_carry <= 1'b0;
            else if (w_wr_fire && w_sum[DW]) r_carry <= 1'b1;
        end
    end

`ifdef ARRAYADD_CTRL_SUM_EN
    logic [DW-1:0] r_total;
    assign total = r_total;

    // Running sum of every write of the current job, wraps at 2^DW
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_total <= '0;
        else if (w_accept)  r_total <= '0;
        else if (w_wr_fire) r_total <= r_total + w_sum[DW-1:0];
    end
`endif

endmodule

// File: tb/tb_arrayadd_ctrl.sv
// Bench for arrayadd_ctrl: directed scenarios plus randomized jobs, each cycle
// compared against a cycle-indexed model of the job (reads at cycles 1..len,
// writes at 2..len+1, done at len+2, abort cuts everything from its cycle on).
module tb_arrayadd_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] b_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, carry;
`ifdef ARRAYADD_CTRL_SUM_EN
  logic [DW-1:0] total;
`endif

  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arrayadd_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .carry(carry)
`ifdef ARRAYADD_CTRL_SUM_EN
    , .total(total)
`endif
  );

  // Synchronous-read memories A and B: data valid the cycle after rd_en
  always @(posedge clk) if (rd_en) begin
    a_data <= mem_a[rd_addr];
    b_data <= mem_b[rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".rd_en"},   rd_en,   0);
    chk({tag, ".wr_en"},   wr_en,   0);
    chk({tag, ".done"},    done,    0);
    chk({tag, ".busy"},    busy,    0);
    chk({tag, ".carry"},   carry,   0);
    chk({tag, ".rd_addr"}, rd_addr, 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_data"}, wr_data, 0);
`ifdef ARRAYADD_CTRL_SUM_EN
    chk({tag, ".total"},   total,   0);
`endif
  endtask

  // Run one job; k = abort cycle (0 = no abort). Checks every cycle until one
  // idle cycle after the job ends.
  task automatic run_job(input int b, input int l, input int k);
    int done_c, last_busy;
    bit exp_carry;
    logic [DW-1:0] exp_total;
    done_c    = (l == 0) ? 1 : l + 2;
    last_busy = (k != 0) ? k : done_c;
    exp_carry = 0;
    exp_total = '0;
    @(negedge clk);
    start = 1'b1; base = b[AW-1:0]; len = l[AW:0];
    abort = 1'($urandom % 2);                 // start must win over abort
    @(posedge clk);                           // edge 0: start accepted
    for (int c = 1; c <= last_busy + 1; c++) begin
      bit e_rd, e_wr;
      int idx;
      logic [DW:0] s;
      #1;
      start = (c <= last_busy) && ($urandom % 3 == 0);   // must be ignored
      if (start) begin base = AW'($urandom); len = (AW+1)'($urandom); end
      abort = (k != 0) ? (c == k) : (c >= done_c && $urandom % 2 == 1);
      e_rd = (c <= l) && (k == 0 || c <= k);
      e_wr = (c >= 2) && (c <= l + 1) && (k == 0 || c < k);
      @(negedge clk);
      chk("busy",  busy,  c <= last_busy);
      chk("done",  done,  k == 0 && c == done_c);
      chk("rd_en", rd_en, e_rd);
      if (e_rd) chk("rd_addr", rd_addr, (b + c - 1) % N);
      chk("wr_en", wr_en, e_wr);
      chk("carry", carry, exp_carry);
`ifdef ARRAYADD_CTRL_SUM_EN
      chk("total", total, exp_total);
`endif
      if (e_wr) begin
        idx = (b + c - 2) % N;
        s = {1'b0, mem_a[idx]} + {1'b0, mem_b[idx]};
        chk("wr_addr", wr_addr, idx);
        chk("wr_data", wr_data, s[DW-1:0]);
        exp_carry = exp_carry | s[DW];
        exp_total = exp_total + s[DW-1:0];
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Reset asserted in cycle 3 of a len=8 job
  task automatic reset_mid_job();
    int act;
    act = 0;
    @(negedge clk);
    start = 1'b1; base = AW'($urandom); len = 8;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outs("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      act += int'(rd_en) + int'(wr_en) + int'(done) + int'(busy);
    end
    chk("rst_quiet", act, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    #2 chk_reset_outs("rst_init");
    @(negedge clk); rst = 1'b0;

    // basic four-element add
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = i + 1;
      mem_b[i] = 10 * (i + 1);
    end
    run_job(0, 4, 0);
    chk("basic_carry", carry, 0);
`ifdef ARRAYADD_CTRL_SUM_EN
    chk("basic_total", total, 110);
`endif

    run_job(254, 4, 0);                         // address wrap
    run_job(int'($urandom_range(0, N - 1)), 0, 0);  // empty job

    mem_a[5] = 32'hFFFF_FFFF;
    mem_b[5] = 32'd2;
    run_job(5, 1, 0);                           // overflow sets carry
    chk("carry_hold", carry, 1);
    run_job(0, 4, 0);                           // next start clears it
    chk("carry_clr", carry, 0);

    run_job(int'($urandom_range(0, N - 1)), 100, 10);  // abort mid READ
    run_job(int'($urandom_range(0, N - 1)), 6, 7);     // abort in DRAIN
    reset_mid_job();
    run_job(int'($urandom_range(0, N - 1)), N, 0);     // full sweep

    for (int j = 0; j < 20; j++) begin
      int l, b, k;
      b = int'($urandom_range(0, N - 1));
      case ($urandom % 6)
        0:       l = 0;
        1:       l = 1;
        default: l = int'($urandom_range(2, 24));
      endcase
      k = (l > 0 && $urandom % 4 == 0) ? int'($urandom_range(1, l + 1)) : 0;
      run_job(b, l, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arrayadd_ctrl.md
ARRAYADD_CTRL -- requirements
Module: arrayadd_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, address width of memories A, B and RESULT.
REQ-002 SHALL have parameter DW, default 32, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-006 SHALL have port base  input  AW  first element index; captured when start is accepted.
REQ-007 SHALL have port len  input  AW+1  element count, 0..2^AW; captured when start is accepted.
REQ-008 SHALL have port abort  input  1  cancel the running job.
REQ-009 SHALL have port rd_en  output  1  read strobe to memories A and B.
REQ-010 SHALL have port rd_addr  output  AW  read index for A and B.
REQ-011 SHALL have port a_data  input  DW  memory A word; valid the cycle after rd_en.
REQ-012 SHALL have port b_data  input  DW  memory B word; valid the cycle after rd_en.
REQ-013 SHALL have port wr_en  output  1  write strobe to memory RESULT.
REQ-014 SHALL have port wr_addr  output  AW  RESULT write index.
REQ-015 SHALL have port wr_data  output  DW  a_data+b_data, truncated to DW.
REQ-016 SHALL have port busy  output  1  high outside IDLE.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port carry  output  1  sticky: some element add of current/last job overflowed DW.

Function
REQ-019 SHALL implement FSM IDLE, READ, DRAIN, DONE.
REQ-020 IDLE: start=1 and len!=0 -> READ; start=1 and len==0 -> DONE with no rd_en/wr_en; start=0 -> stay.
REQ-021 Accepting start SHALL clear carry and internal element counter.
REQ-022 READ: rd_en=1 every cycle, rd_addr=(base+counter) mod 2^AW; counter increments; after len-th read -> DRAIN.
REQ-023 Each read SHALL produce, exactly one cycle later, wr_en=1, wr_addr=that read's rd_addr, wr_data=(a_data+b_data) mod 2^DW.
REQ-024 DRAIN: rd_en=0, final write issued, -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-026 Latency: start accepted at edge 0 -> first rd_en cycle 1, last wr_en cycle len+1, done cycle len+2; len==0 -> done cycle 1.
REQ-027 Address wrap: base+counter past 2^AW-1 SHALL wrap to 0; len=2^AW SHALL touch every index once.
REQ-028 carry SHALL set when bit DW of a_data+b_data is 1 on any write, hold until next accepted start or reset.
REQ-029 start while busy=1 SHALL be ignored, not queued.
REQ-030 abort=1 in READ or DRAIN SHALL force IDLE next edge; in-flight write squashed; no done pulse; carry holds.
REQ-031 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE: start wins.
REQ-032 rd_en and wr_en SHALL be 0 in IDLE and DONE.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, busy=0, done=0, rd_en=0, wr_en=0, carry=0, rd_addr=0, wr_addr=0, wr_data=0, counter=0.
REQ-034 Reset mid-job SHALL abandon the job with no further memory writes; no done pulse.

Configuration
REQ-035 Macro ARRAYADD_CTRL_SUM_EN defined: SHALL add output total (DW) = running sum of all wr_data of current job mod 2^DW, cleared on accepted start and reset, stable after done.
REQ-036 Macro undefined: port total and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-037 base=0, len=4, A={1,2,3,4}, B={10,20,30,40} -> RESULT[0..3]={11,22,33,44}, done cycle 6, carry=0, total=110 with SUM_EN.
REQ-038 base=254, len=4 -> writes at 254,255,0,1 in order; done cycle 6.
REQ-039 len=0 -> no rd_en/wr_en, done at cycle 1, busy high one cycle.
REQ-040 A[5]=0xFFFFFFFF, B[5]=2, base=5, len=1 -> wr_data=1, carry=1 after done; next start clears carry.
REQ-041 len=100, abort at cycle 10 -> no rd_en/wr_en from cycle 11, no done; start during job ignored.
REQ-042 rst asserted cycle 3 of len=8 job -> all outputs reset values immediately, no later writes.
